mem_ahb_master: RTL and testbench
=================================

# mem_ahb_master

Memory-stage AHB-Lite data master of the MIPS_AHB pipeline. It sits between the EX/MEM register and the MEM/WB register, converting M-stage load/store requests into single AHB-Lite transfers. The address phase is issued in M. The data phase completes while the instruction is in W, so formatted load data is delivered straight to the writeback mux as ReadData_W; the MEM/WB register carries no read data. It generates the pipeline stall for wait states and bus errors.

## Interface
- No parameters; widths are fixed at 32-bit data/address.
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- EN_M  in  1  M-stage instruction advances this cycle; same enable as the MEM/WB register
- MemRead_M, MemWrite_M  in  1 each  load / store request
- ByteControl_M  in  2  00 word, 01 half, 10 byte, 11 treated as word
- LoadUnsigned_M  in  1  zero-extend sub-word loads
- ALU_result_M  in  32  effective address
- WriteData_M  in  32  store data, right-aligned
- HADDR  out  32, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3, HBURST  out  3 (constant 000 SINGLE), HWDATA  out  32
- HRDATA  in  32, HREADY  in  1, HRESP  in  1
- Stall_M  out  1  freeze IF..M and the MEM/WB register
- ReadData_W  out  32  formatted load data for W
- BusError  out  1  one-cycle pulse when an error response completes
- Misaligned_M  out  1  M request is misaligned; no transfer is issued

## Operation
- Request: req = (MemRead_M | MemWrite_M) & !Misaligned_M & !issued.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. This is combinational.
- Address phase (combinational from M inputs):
  - HTRANS = NONSEQ (10) when req and state≠ERR; otherwise IDLE (00).
  - HADDR = ALU_result_M.
  - HWRITE = MemWrite_M.
  - HSIZE = 000 byte, 001 half, 010 word.
  - M inputs are stable under a stall because EN_M is low.
- issued flag: set when a NONSEQ is accepted (HREADY=1); cleared when EN_M=1. This guarantees exactly one transfer per instruction even if EN_M is held low by another hazard.
- On acceptance, the block registers: write flag, size, addr[1:0], LoadUnsigned.
- HWDATA is registered at acceptance and driven during the data phase:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- FSM:
  - IDLE → DPHASE on accepted NONSEQ.
  - DPHASE with HREADY=1, HRESP=0: transfer done. Go to DPHASE if a new NONSEQ is accepted in the same cycle, else IDLE.
  - DPHASE with HRESP=1, HREADY=0 → ERR. HTRANS is forced IDLE in this cycle, cancelling any overlapping request; issued is not set.
  - ERR with HREADY=1 → IDLE and pulse BusError. The cancelled request reissues next cycle.
- Stall_M = (DPHASE & !HREADY) | ERR.
- Load formatting, little-endian, from the registered offset:
  - byte: HRDATA[8*off +: 8]
  - half: HRDATA[16*off[1] +: 16]
  - Sign- or zero-extended per LoadUnsigned.
- ReadData_W:
  - Equals the formatted HRDATA in the completing cycle of a load (DPHASE, HREADY=1, HRESP=0).
  - That value is also captured into rd_hold at the same edge.
  - Otherwise ReadData_W = rd_hold, so W stalls from other sources do not lose data.

## Timing
- Reset (async, immediate) values:
  - state IDLE, issued 0, HTRANS 00, HWRITE 0, HSIZE 000, HBURST 000.
  - HWDATA 0, rd_hold 0, ReadData_W 0, BusError 0.
  - HADDR follows ALU_result_M.
- Reset mid-transfer: bus outputs return to IDLE at once; the slave's later completion is ignored.
- Zero-wait load:
  - Cycle n: NONSEQ in M.
  - Cycle n+1: instruction in W; ReadData_W valid, Stall_M 0.
- N wait states give Stall_M high for N cycles. The overlapping next address is held for those N cycles.
- Error: Stall_M is high for 2 cycles. BusError is high in the cycle after the second error cycle.
- Back-to-back accesses sustain one transfer per cycle.

## Structure
- mips_ahb_pkg holds:
  - HTRANS constants IDLE/NONSEQ
  - HSIZE codes
  - ByteControl encoding
  - FSM state enum {IDLE, DPHASE, ERR}
- Sub-module load_formatter (combinational): HRDATA, offset, size, unsigned → 32-bit result.

## Test plan
- Word load @0x100, HRDATA 0xDEADBEEF, no waits → NONSEQ, HSIZE 010 in cycle 0; ReadData_W=0xDEADBEEF in cycle 1; Stall_M never high.
- Signed byte load @0x103, HRDATA 0x80123456, 2 wait states → Stall_M high 2 cycles; ReadData_W=0xFFFFFF80. Repeat unsigned → 0x00000080, held after completion.
- Half store @0x202, data 0x1234ABCD → HWRITE 1, HSIZE 001; HWDATA 0xABCDABCD in data phase.
- Load @0x10 then store @0x14, HREADY low 1 cycle in the load's data phase → store address held 2 cycles; exactly one accepted NONSEQ per instruction.
- Error response on a load with a store pending → HTRANS IDLE in error cycle 1; Stall_M 2 cycles; BusError pulse; store reissued once.
- Word load @0x101 → Misaligned_M 1, no NONSEQ. Then a valid load with EN_M low 3 cycles → single transfer only.

Source files
------------

// File: rtl/mips_ahb_pkg.sv
//------------------------------------------------------------------------------
// Module      : mips_ahb_pkg
// Description : Shared AHB-Lite encodings, ByteControl codes and the FSM state
//               type for the MIPS_AHB memory-stage data master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_ahb_pkg;

   // AHB-Lite transfer types used by a single-transfer master
   localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;

   // AHB-Lite transfer sizes
   localparam logic [2:0] C_HSIZE_BYTE = 3'b000;
   localparam logic [2:0] C_HSIZE_HALF = 3'b001;
   localparam logic [2:0] C_HSIZE_WORD = 3'b010;

   // Only single transfers are ever issued
   localparam logic [2:0] C_HBURST_SINGLE = 3'b000;

   // Pipeline ByteControl encoding (2'b11 behaves as word)
   localparam logic [1:0] C_BC_WORD = 2'b00;
   localparam logic [1:0] C_BC_HALF = 2'b01;
   localparam logic [1:0] C_BC_BYTE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DPHASE = 2'b01,
      ST_ERR    = 2'b10
   } state_e;

   // Map the pipeline access width onto an AHB HSIZE code
   function automatic logic [2:0] bc_to_hsize(input logic [1:0] bc);
      case (bc)
         C_BC_HALF: bc_to_hsize = C_HSIZE_HALF;
         C_BC_BYTE: bc_to_hsize = C_HSIZE_BYTE;
         default:   bc_to_hsize = C_HSIZE_WORD;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ahb_master_load_formatter.sv
//------------------------------------------------------------------------------
// Module      : load_formatter
// Description : Extracts a little-endian byte/half/word lane from HRDATA and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_formatter
   import mips_ahb_pkg::*;
(
   input  logic [31:0] hrdata_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] result_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane select followed by extension according to the access size
   always_comb begin
      case (offset_i)
         2'd0:    w_byte = hrdata_i[7:0];
         2'd1:    w_byte = hrdata_i[15:8];
         2'd2:    w_byte = hrdata_i[23:16];
         default: w_byte = hrdata_i[31:24];
      endcase
      w_half = offset_i[1] ? hrdata_i[31:16] : hrdata_i[15:0];
      case (size_i)
         C_HSIZE_BYTE: result_o = {{24{w_byte[7] & ~unsigned_i}}, w_byte};
         C_HSIZE_HALF: result_o = {{16{w_half[15] & ~unsigned_i}}, w_half};
         default:      result_o = hrdata_i;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_ahb_master.sv
//------------------------------------------------------------------------------
// Module      : mem_ahb_master
// Description : M-stage AHB-Lite data master. Issues one single transfer per
//               load/store, completes the data phase while the instruction is
//               in W, and stalls the pipeline on wait states and errors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_ahb_master
   import mips_ahb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        EN_M,
   input  logic        MemRead_M,
   input  logic        MemWrite_M,
   input  logic [1:0]  ByteControl_M,
   input  logic        LoadUnsigned_M,
   input  logic [31:0] ALU_result_M,
   input  logic [31:0] WriteData_M,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        Stall_M,
   output logic [31:0] ReadData_W,
   output logic        BusError,
   output logic        Misaligned_M
);

   state_e      state_q, state_d;
   logic        issued_q, issued_d;
   logic        wr_q;
   logic [2:0]  size_q;
   logic [1:0]  off_q;
   logic        lu_q;
   logic [31:0] hwdata_q;
   logic [31:0] rd_hold_q;
   logic        bus_err_q;

   logic        w_misaligned;
   logic        w_req;
   logic        w_err_first;
   logic        w_nonseq;
   logic        w_accept;
   logic        w_load_done;
   logic        w_err_done;
   logic [2:0]  w_hsize;
   logic [31:0] w_wdata_rep;
   logic [31:0] w_fmt;

   // Request qualification and address-phase control, all from M-stage inputs
   always_comb begin
      w_hsize      = bc_to_hsize(ByteControl_M);
      w_misaligned = ((w_hsize == C_HSIZE_HALF) & ALU_result_M[0]) |
                     ((w_hsize == C_HSIZE_WORD) & (|ALU_result_M[1:0]));
      w_req        = (MemRead_M | MemWrite_M) & ~w_misaligned & ~issued_q;
      // First error cycle cancels any overlapping request so it reissues later
      w_err_first  = (state_q == ST_DPHASE) & HRESP & ~HREADY;
      w_nonseq     = rst_n & w_req & (state_q != ST_ERR) & ~w_err_first;
      w_accept     = w_nonseq & HREADY;
      w_load_done  = (state_q == ST_DPHASE) & HREADY & ~HRESP & ~wr_q;
      w_err_done   = (state_q == ST_ERR) & HREADY;
      case (w_hsize)
         C_HSIZE_BYTE: w_wdata_rep = {4{WriteData_M[7:0]}};
         C_HSIZE_HALF: w_wdata_rep = {2{WriteData_M[15:0]}};
         default:      w_wdata_rep = WriteData_M;
      endcase
   end

   // Next-state for the transfer FSM and the one-transfer-per-instruction flag
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) state_d = ST_DPHASE;
         end
         ST_DPHASE: begin
            if (HREADY)     state_d = w_accept ? ST_DPHASE : ST_IDLE;
            else if (HRESP) state_d = ST_ERR;
         end
         ST_ERR: begin
            if (HREADY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (EN_M)          issued_d = 1'b0;
      else if (w_accept) issued_d = 1'b1;
      else               issued_d = issued_q;
   end

   // FSM state, data-phase attributes, store data and load-data hold register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         issued_q  <= 1'b0;
         wr_q      <= 1'b0;
         size_q    <= C_HSIZE_BYTE;
         off_q     <= 2'b00;
         lu_q      <= 1'b0;
         hwdata_q  <= 32'h0;
         rd_hold_q <= 32'h0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         issued_q  <= issued_d;
         bus_err_q <= w_err_done;
         if (w_accept) begin
            wr_q     <= MemWrite_M;
            size_q   <= w_hsize;
            off_q    <= ALU_result_M[1:0];
            lu_q     <= LoadUnsigned_M;
            hwdata_q <= w_wdata_rep;
         end
         if (w_load_done) rd_hold_q <= w_fmt;
      end
   end

   load_formatter u_load_formatter (
      .hrdata_i   (HRDATA),
      .offset_i   (off_q),
      .size_i     (size_q),
      .unsigned_i (lu_q),
      .result_o   (w_fmt)
   );

   assign HADDR        = ALU_result_M;
   assign HTRANS       = w_nonseq ? C_HTRANS_NONSEQ : C_HTRANS_IDLE;
   assign HWRITE       = rst_n & MemWrite_M;
   assign HSIZE        = rst_n ? w_hsize : C_HSIZE_BYTE;
   assign HBURST       = C_HBURST_SINGLE;
   assign HWDATA       = hwdata_q;
   assign Stall_M      = ((state_q == ST_DPHASE) & ~HREADY) | (state_q == ST_ERR);
   assign ReadData_W   = w_load_done ? w_fmt : rd_hold_q;
   assign BusError     = bus_err_q;
   assign Misaligned_M = w_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_mem_ahb_master.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_ahb_master
// Description : Self-checking bench for mem_ahb_master: a scripted M-stage
//               driver, a reactive AHB-Lite slave and a transfer scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_ahb_master;

   logic        clk, rst_n, EN_M, MemRead_M, MemWrite_M, LoadUnsigned_M;
   logic [1:0]  ByteControl_M, HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic [31:0] ALU_result_M, WriteData_M, HADDR, HWDATA, HRDATA, ReadData_W;
   logic        HWRITE, HREADY, HRESP, Stall_M, BusError, Misaligned_M;
   logic        hold_en;

   int errors    = 0;
   int checks    = 0;
   int stall_cnt = 0;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } xfer_t;

   typedef struct {
      int          waits;
      bit          err;
      logic [31:0] rdata;
   } resp_t;

   xfer_t exp_q[$];
   resp_t resp_q[$];

   // The pipeline advances M unless this block stalls or another hazard holds it
   assign EN_M = rst_n & ~Stall_M & ~hold_en;

   mem_ahb_master dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .EN_M           (EN_M),
      .MemRead_M      (MemRead_M),
      .MemWrite_M     (MemWrite_M),
      .ByteControl_M  (ByteControl_M),
      .LoadUnsigned_M (LoadUnsigned_M),
      .ALU_result_M   (ALU_result_M),
      .WriteData_M    (WriteData_M),
      .HADDR          (HADDR),
      .HTRANS         (HTRANS),
      .HWRITE         (HWRITE),
      .HSIZE          (HSIZE),
      .HBURST         (HBURST),
      .HWDATA         (HWDATA),
      .HRDATA         (HRDATA),
      .HREADY         (HREADY),
      .HRESP          (HRESP),
      .Stall_M        (Stall_M),
      .ReadData_W     (ReadData_W),
      .BusError       (BusError),
      .Misaligned_M   (Misaligned_M)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Queue one expected bus transfer together with the slave response for it
   task automatic expect_xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [31:0] wdat, input logic [31:0] rexp,
                              input logic [31:0] hrd, input int waits, input bit err);
      xfer_t x;
      resp_t r;
      x.addr = a; x.wr = w; x.size = sz; x.wdata = wdat; x.rdata = rexp;
      r.waits = waits; r.err = err; r.rdata = hrd;
      exp_q.push_back(x);
      resp_q.push_back(r);
   endtask

   // Present one instruction in M and hold it until EN_M lets it advance
   task automatic instr(input logic rd, input logic wr, input logic [1:0] bc, input logic lu,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output int ncyc, output logic mis);
      logic en;
      bit   done;
      MemRead_M = rd; MemWrite_M = wr; ByteControl_M = bc; LoadUnsigned_M = lu;
      ALU_result_M = a; WriteData_M = wd;
      hold_en = (hold > 0);
      ncyc = 0; done = 0; mis = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         ncyc++;
         en = EN_M;
         if (ncyc == 1) mis = Misaligned_M;
         @(posedge clk);
         #1;
         if (en) done = 1;
         else if (ncyc >= hold) hold_en = 0;
      end
      chk("instr_advance", done, 1'b1);
   endtask

   task automatic nop();
      int   n;
      logic m;
      instr(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 0, n, m);
   endtask

   // Reactive slave plus bus monitor: pops the scoreboard on every accepted NONSEQ
   initial begin : slave
      xfer_t cur;
      resp_t rsp;
      bit    in_dp, acc, be_pend;
      int    waits_left, err_stage;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
      in_dp = 0; acc = 0; be_pend = 0; waits_left = 0; err_stage = 0;
      rsp.waits = 0; rsp.err = 0; rsp.rdata = 32'h0;
      cur.addr = 0; cur.wr = 0; cur.size = 0; cur.wdata = 0; cur.rdata = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("buserror", BusError, be_pend);
            be_pend = 0;
            if (Stall_M) stall_cnt++;
            if (in_dp && HRESP && !HREADY) chk("err_htrans", HTRANS, 2'b00);
            if (in_dp && HREADY) begin
               if (HRESP)       be_pend = 1;
               else if (cur.wr) chk("hwdata", HWDATA, cur.wdata);
               else             chk("readdata", ReadData_W, cur.rdata);
               in_dp = 0;
            end
            acc = (HTRANS == 2'b10) && HREADY;
            if (acc) begin
               chk("xfer_expected", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0) begin
                  cur = exp_q.pop_front();
                  chk("haddr", HADDR, cur.addr);
                  chk("hwrite", HWRITE, cur.wr);
                  chk("hsize", HSIZE, cur.size);
               end
            end
         end
         @(posedge clk);
         #1;
         if (acc) begin
            if (resp_q.size() > 0) rsp = resp_q.pop_front();
            else begin rsp.waits = 0; rsp.err = 0; rsp.rdata = 32'h0; end
            in_dp = 1; waits_left = rsp.waits; err_stage = 0; acc = 0;
         end
         if (in_dp) begin
            if (rsp.err) begin
               HRESP = 1'b1; HREADY = (err_stage != 0); err_stage = 1;
            end else if (waits_left > 0) begin
               HREADY = 1'b0; HRESP = 1'b0; waits_left--;
            end else begin
               HREADY = 1'b1; HRESP = 1'b0; HRDATA = rsp.rdata;
            end
         end else begin
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
         end
      end
   end

   initial begin : main
      int   n;
      logic mis;
      rst_n = 1'b1; hold_en = 1'b0;
      MemRead_M = 1'b0; MemWrite_M = 1'b1; ByteControl_M = 2'b00; LoadUnsigned_M = 1'b0;
      ALU_result_M = 32'h0000_0055; WriteData_M = 32'h0000_1234;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_htrans", HTRANS, 2'b00);
      chk("rst_hwrite", HWRITE, 1'b0);
      chk("rst_hsize", HSIZE, 3'b000);
      chk("rst_hburst", HBURST, 3'b000);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_readdata", ReadData_W, 32'h0);
      chk("rst_buserror", BusError, 1'b0);
      chk("rst_stall", Stall_M, 1'b0);
      chk("rst_haddr", HADDR, 32'h0000_0055);
      @(posedge clk); #1;
      MemWrite_M = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Zero-wait word load
      stall_cnt = 0;
      expect_xfer(32'h100, 1'b0, 3'b010, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
      instr(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 0, n, mis);
      chk("t1_cycles", n, 1);
      nop();
      chk("t1_stall", stall_cnt, 0);

      // Signed then unsigned byte load at offset 3 with two wait states
      stall_cnt = 0;
      expect_xfer(32'h103, 1'b0, 3'b000, 32'h0, 32'hFFFFFF80, 32'h80123456, 2, 0);
      instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 0, n, mis);
      nop();
      chk("t2_stall", stall_cnt, 2);
      expect_xfer(32'h103, 1'b0, 3'b000, 32'h0, 32'h00000080, 32'h80123456, 2, 0);
      instr(1'b1, 1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 0, n, mis);
      nop();
      nop();
      @(negedge clk);
      chk("t2_hold", ReadData_W, 32'h00000080);
      @(posedge clk); #1;

      // Half store replicates the halfword on both lanes
      expect_xfer(32'h202, 1'b1, 3'b001, 32'hABCDABCD, 32'h0, 32'h0, 0, 0);
      instr(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 0, n, mis);
      nop();

      // Load with one wait state overlapping the following store's address
      expect_xfer(32'h10, 1'b0, 3'b010, 32'h0, 32'h11223344, 32'h11223344, 1, 0);
      expect_xfer(32'h14, 1'b1, 3'b010, 32'hCAFEF00D, 32'h0, 32'h0, 0, 0);
      instr(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0, n, mis);
      instr(1'b0, 1'b1, 2'b00, 1'b0, 32'h14, 32'hCAFEF00D, 0, n, mis);
      chk("t4_store_held", n, 2);
      nop();

      // Error response on a load with a byte store pending behind it
      stall_cnt = 0;
      expect_xfer(32'h40, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 1);
      expect_xfer(32'h45, 1'b1, 3'b000, 32'hA5A5A5A5, 32'h0, 32'h0, 0, 0);
      instr(1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 0, n, mis);
      instr(1'b0, 1'b1, 2'b10, 1'b0, 32'h45, 32'h000000A5, 0, n, mis);
      chk("t5_store_cycles", n, 3);
      nop();
      chk("t5_stall", stall_cnt, 2);

      // Misaligned word load issues nothing
      instr(1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 0, n, mis);
      chk("t6_misaligned", mis, 1'b1);
      // Aligned unsigned half load held by another hazard for three cycles
      expect_xfer(32'h22, 1'b0, 3'b001, 32'h0, 32'h0000BEEF, 32'hBEEF0000, 0, 0);
      instr(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 3, n, mis);
      chk("t6_misaligned_ok", mis, 1'b0);
      chk("t6_hold_cycles", n, 4);
      // Signed half load from the low lane
      expect_xfer(32'h30, 1'b0, 3'b001, 32'h0, 32'hFFFF8001, 32'h00008001, 0, 0);
      instr(1'b1, 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 0, n, mis);
      nop();
      nop();

      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
